// File: rtl/lf_spi_cmd_rx.sv
// lf_spi_cmd_rx: pck0-domain SPI command receiver that decodes 16-bit frames into LF config registers.
// Define LF_SPI_CMD_READBACK_EN to shift the last accepted command word back out on miso.
module lf_spi_cmd_rx #(
    parameter int          CMD_BITS    = 16,
    parameter logic [11:0] RST_CONF    = 12'h1C0,
    parameter logic [7:0]  RST_DIVISOR = 8'd95
) (
    input  logic        pck0,
    input  logic        nrst,
    input  logic        spck,
    input  logic        mosi,
    input  logic        ncs,
    output logic        miso,
    output logic [11:0] conf_word,
    output logic [7:0]  divisor,
    output logic [7:0]  lf_ed_threshold,
    output logic        cmd_strobe,
    output logic        frame_err,
    output logic [7:0]  err_cnt
);

    localparam logic [3:0] OP_SET_CONFREG     = 4'd1;
    localparam logic [3:0] OP_SET_DIVISOR     = 4'd2;
    localparam logic [3:0] OP_SET_ED_THRESH   = 4'd3;
    localparam logic [2:0] MODE_LF_EDGE_DET   = 3'd1;
    localparam logic [7:0] RST_THRESHOLD      = 8'd127;
    localparam logic [4:0] FULL_CNT           = 5'(CMD_BITS);
    localparam logic [4:0] SAT_CNT            = 5'(CMD_BITS + 1);

    logic spck_meta, spck_s, spck_d;
    logic mosi_meta, mosi_s;
    logic ncs_meta,  ncs_s,  ncs_d;

    logic [CMD_BITS-1:0] shift_reg;
    logic [4:0]          bit_cnt;

    logic       spck_rise, ncs_rise, ncs_fall;
    logic [3:0] opcode;
    logic [11:0] payload;
    logic       frame_ok, cmd_hit;

    // NOTE: the ncs chain resets to its idle (high) level so leaving reset never fakes a frame end.
    // If ncs is already low at release, the resulting "fall" only re-clears an already-empty frame.
    always_ff @(posedge pck0 or negedge nrst) begin
        if (!nrst) begin
            spck_meta <= 1'b0;
            spck_s    <= 1'b0;
            spck_d    <= 1'b0;
            mosi_meta <= 1'b0;
            mosi_s    <= 1'b0;
            ncs_meta  <= 1'b1;
            ncs_s     <= 1'b1;
            ncs_d     <= 1'b1;
        end else begin
            spck_meta <= spck;
            spck_s    <= spck_meta;
            spck_d    <= spck_s;
            mosi_meta <= mosi;
            mosi_s    <= mosi_meta;
            ncs_meta  <= ncs;
            ncs_s     <= ncs_meta;
            ncs_d     <= ncs_s;
        end
    end

    assign spck_rise = spck_s & ~spck_d;
    assign ncs_rise  = ncs_s & ~ncs_d;
    assign ncs_fall  = ~ncs_s & ncs_d;

    assign opcode   = shift_reg[CMD_BITS-1 -: 4];
    assign payload  = shift_reg[11:0];
    assign frame_ok = (bit_cnt == FULL_CNT);
    assign cmd_hit  = frame_ok && ((opcode == OP_SET_CONFREG) ||
                                   (opcode == OP_SET_DIVISOR) ||
                                   (opcode == OP_SET_ED_THRESH));

    // A bit arriving together with the ncs rise sees ncs_s high and is dropped.
    always_ff @(posedge pck0 or negedge nrst) begin
        if (!nrst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (ncs_fall) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (spck_rise && !ncs_s) begin
            shift_reg <= {shift_reg[CMD_BITS-2:0], mosi_s};
            if (bit_cnt != SAT_CNT) begin
                bit_cnt <= bit_cnt + 5'd1;
            end
        end
    end

    always_ff @(posedge pck0 or negedge nrst) begin
        if (!nrst) begin
            conf_word       <= RST_CONF;
            divisor         <= RST_DIVISOR;
            lf_ed_threshold <= RST_THRESHOLD;
            cmd_strobe      <= 1'b0;
            frame_err       <= 1'b0;
            err_cnt         <= 8'd0;
        end else begin
            cmd_strobe <= 1'b0;
            frame_err  <= 1'b0;
            if (ncs_rise) begin
                if (frame_ok) begin
                    cmd_strobe <= cmd_hit;
                    case (opcode)
                        OP_SET_CONFREG: begin
                            conf_word <= payload;
                            // Entering LF edge-detect mode restores the default threshold.
                            if (payload[8:6] == MODE_LF_EDGE_DET) begin
                                lf_ed_threshold <= RST_THRESHOLD;
                            end
                        end
                        OP_SET_DIVISOR:   divisor         <= payload[7:0];
                        OP_SET_ED_THRESH: lf_ed_threshold <= payload[7:0];
                        default: ;
                    endcase
                end else begin
                    frame_err <= 1'b1;
                    if (err_cnt != 8'hFF) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                end
            end
        end
    end

`ifdef LF_SPI_CMD_READBACK_EN
    logic                spck_fall;
    logic [CMD_BITS-1:0] last_word;
    logic [CMD_BITS-1:0] rb_shift;

    assign spck_fall = ~spck_s & spck_d;

    // The word is captured on accept and only reaches the shifter at the next frame start.
    always_ff @(posedge pck0 or negedge nrst) begin
        if (!nrst) begin
            last_word <= '0;
            rb_shift  <= '0;
        end else begin
            if (ncs_rise && cmd_hit) begin
                last_word <= shift_reg;
            end
            if (ncs_fall) begin
                rb_shift <= last_word;
            end else if (spck_fall && !ncs_s) begin
                rb_shift <= {rb_shift[CMD_BITS-2:0], 1'b0};
            end
        end
    end

    assign miso = ~ncs_s & rb_shift[CMD_BITS-1];
`else
    assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_lf_spi_cmd_rx.sv
// Self-checking bench for lf_spi_cmd_rx: directed and random SPI frames against a frame-level model.
// Readback checks follow LF_SPI_CMD_READBACK_EN; without it miso must stay 0.
module tb_lf_spi_cmd_rx;

    localparam logic [11:0] RST_CONF = 12'h1C0;
    localparam logic [7:0]  RST_DIV  = 8'd95;
    localparam logic [7:0]  RST_THR  = 8'd127;
`ifdef LF_SPI_CMD_READBACK_EN
    localparam bit RB_EN = 1'b1;
`else
    localparam bit RB_EN = 1'b0;
`endif

    logic        pck0 = 1'b0;
    logic        nrst = 1'b0;
    logic        spck = 1'b0;
    logic        mosi = 1'b0;
    logic        ncs  = 1'b1;
    logic        miso;
    logic [11:0] conf_word;
    logic [7:0]  divisor;
    logic [7:0]  lf_ed_threshold;
    logic        cmd_strobe;
    logic        frame_err;
    logic [7:0]  err_cnt;

    lf_spi_cmd_rx dut (
        .pck0            (pck0),
        .nrst            (nrst),
        .spck            (spck),
        .mosi            (mosi),
        .ncs             (ncs),
        .miso            (miso),
        .conf_word       (conf_word),
        .divisor         (divisor),
        .lf_ed_threshold (lf_ed_threshold),
        .cmd_strobe      (cmd_strobe),
        .frame_err       (frame_err),
        .err_cnt         (err_cnt)
    );

    always #5 pck0 = ~pck0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame-level reference model
    logic [11:0] m_conf;
    logic [7:0]  m_div, m_thr, m_err;
    logic [15:0] m_last;

    logic [63:0] fr_bits;
    int          fr_n;
    logic [63:0] rb_obs;
    logic [15:0] rb_start;

    task automatic model_reset();
        m_conf = RST_CONF;
        m_div  = RST_DIV;
        m_thr  = RST_THR;
        m_err  = 8'd0;
        m_last = 16'd0;
    endtask

    task automatic start_frame();
        @(negedge pck0);
        spck     = 1'b0;
        ncs      = 1'b0;
        fr_bits  = '0;
        fr_n     = 0;
        rb_obs   = '0;
        rb_start = m_last;
        repeat (4) @(negedge pck0);
    endtask

    task automatic send_bit(input logic b);
        mosi = b;
        repeat (4) @(negedge pck0);
        rb_obs = {rb_obs[62:0], miso};
        spck = 1'b1;
        repeat (4) @(negedge pck0);
        spck = 1'b0;
        fr_bits = {fr_bits[62:0], b};
        fr_n++;
    endtask

    task automatic finish_frame(input bit extra_clk, input string tag);
        logic [11:0] old_conf;
        logic [7:0]  old_div, old_thr;
        logic [15:0] w;
        logic [63:0] exp_rb;
        bit          exp_strobe, exp_err;
        logic [7:0]  s_cnt, s_at, e_cnt, e_at;
        repeat (4) @(negedge pck0);
        old_conf = m_conf;
        old_div  = m_div;
        old_thr  = m_thr;
        exp_rb   = '0;
        for (int i = 0; i < fr_n; i++) begin
            if (RB_EN && i < 16) exp_rb[fr_n-1-i] = rb_start[15-i];
        end
        exp_strobe = 1'b0;
        exp_err    = 1'b0;
        if (fr_n == 16) begin
            w = fr_bits[15:0];
            case (w[15:12])
                4'd1: begin
                    m_conf = w[11:0];
                    if (w[8:6] == 3'd1) m_thr = 8'd127;
                    exp_strobe = 1'b1;
                end
                4'd2: begin m_div = w[7:0]; exp_strobe = 1'b1; end
                4'd3: begin m_thr = w[7:0]; exp_strobe = 1'b1; end
                default: ;
            endcase
            if (exp_strobe) m_last = w;
        end else begin
            exp_err = 1'b1;
            if (m_err != 8'hFF) m_err = m_err + 8'd1;
        end
        if (extra_clk) spck = 1'b1;
        ncs   = 1'b1;
        s_cnt = 0; s_at = 0; e_cnt = 0; e_at = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge pck0);
            if (cmd_strobe) begin s_cnt++; s_at = 8'(i); end
            if (frame_err)  begin e_cnt++; e_at = 8'(i); end
            if (i == 2) check({tag, " hold"}, 64'({conf_word, divisor, lf_ed_threshold}),
                              64'({old_conf, old_div, old_thr}));
        end
        spck = 1'b0;
        check({tag, " strobe"}, 64'({s_cnt, s_at}), exp_strobe ? 64'h0103 : 64'h0);
        check({tag, " ferr"},   64'({e_cnt, e_at}), exp_err ? 64'h0103 : 64'h0);
        check({tag, " conf"},   64'(conf_word), 64'(m_conf));
        check({tag, " div"},    64'(divisor), 64'(m_div));
        check({tag, " thr"},    64'(lf_ed_threshold), 64'(m_thr));
        check({tag, " errcnt"}, 64'(err_cnt), 64'(m_err));
        check({tag, " miso"},   rb_obs, exp_rb);
        check({tag, " miso idle"}, 64'(miso), 64'h0);
        repeat (3) @(negedge pck0);
    endtask

    task automatic spi_frame(input logic [63:0] bits, input int n, input bit extra_clk, input string tag);
        start_frame();
        for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
        finish_frame(extra_clk, tag);
    endtask

    initial begin
        logic [63:0] bits;
        int          n, sel;
        model_reset();
        repeat (3) @(negedge pck0);
        check("rst conf",   64'(conf_word), 64'(RST_CONF));
        check("rst div",    64'(divisor), 64'(RST_DIV));
        check("rst thr",    64'(lf_ed_threshold), 64'(RST_THR));
        check("rst pulses", 64'({cmd_strobe, frame_err}), 64'h0);
        check("rst errcnt", 64'(err_cnt), 64'h0);
        check("rst miso",   64'(miso), 64'h0);
        nrst = 1'b1;
        repeat (4) @(negedge pck0);

        spi_frame(64'h11C5, 16, 1'b0, "confreg");
        spi_frame(64'h3040, 16, 1'b0, "thresh");
        spi_frame(64'h1040, 16, 1'b0, "conf mode1");
        spi_frame(64'h5A5A, 15, 1'b0, "short15");
        spi_frame(64'h2D2D5, 18, 1'b0, "long18");
        spi_frame(64'h7ABC, 16, 1'b0, "opcode7");
        spi_frame(64'h2060, 16, 1'b0, "divisor");
        spi_frame(64'h0000, 16, 1'b0, "readback");
        spi_frame(64'h2042, 16, 1'b1, "spck+ncs");
        spi_frame({16'h0, 32'hDEADBEEF, 16'h2033}, 48, 1'b0, "long48");

        for (int t = 0; t < 40; t++) begin
            bits = {$urandom(), $urandom()};
            sel  = $urandom_range(0, 9);
            n    = 16;
            if (sel <= 2) begin
                bits[15:12] = 4'd1;
                if ($urandom_range(0, 1) == 1) bits[8:6] = 3'd1;
            end else if (sel <= 4) begin
                bits[15:12] = 4'd2;
            end else if (sel <= 6) begin
                bits[15:12] = 4'd3;
            end else if (sel == 7) begin
                bits[15:12] = 4'($urandom_range(4, 15));
            end else if (sel == 8) begin
                n = $urandom_range(1, 15);
            end else begin
                n = $urandom_range(17, 24);
            end
            spi_frame(bits, n, 1'b0, $sformatf("rand%0d", t));
        end

        // Reset in the middle of a SET_DIVISOR frame while ncs stays low
        bits = 64'h2042;
        start_frame();
        for (int i = 15; i >= 8; i--) send_bit(bits[i]);
        @(negedge pck0);
        nrst = 1'b0;
        repeat (2) @(negedge pck0);
        check("midrst div",    64'(divisor), 64'(RST_DIV));
        check("midrst errcnt", 64'(err_cnt), 64'h0);
        nrst = 1'b1;
        model_reset();
        fr_bits  = '0;
        fr_n     = 0;
        rb_obs   = '0;
        rb_start = 16'h0;
        repeat (4) @(negedge pck0);
        for (int i = 7; i >= 0; i--) send_bit(bits[i]);
        finish_frame(1'b0, "midrst");

        // Empty frames drive the error counter into saturation
        for (int t = 0; t < 258; t++) begin
            start_frame();
            finish_frame(1'b0, "sat");
        end
        check("sat final", 64'(err_cnt), 64'hFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
